// File: rtl/translate_pkg.sv
// Shared types for the translate gather reader: pixel type,
// control FSM states and output FIFO depth.
package translate_pkg;

  typedef logic [7:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam int FIFO_DEPTH = 2;

  typedef struct packed {
    pixel_t data;
    logic   sol;
    logic   eof;
  } pix_t;

endpackage

// File: rtl/translate_pix_fifo.sv
// Two-entry output FIFO holding pixel data plus sol/eof tags.
// Caller never pushes when full unless it pops the same cycle.
module translate_pix_fifo
  import translate_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       push_sol,
  input  logic       push_eof,
  input  logic       pop,
  output logic [7:0] head_data,
  output logic       head_sol,
  output logic       head_eof,
  output logic [1:0] count
);

  pix_t       mem_q [FIFO_DEPTH];
  pix_t       mem_d [FIFO_DEPTH];
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{data: push_data, sol: push_sol, eof: push_eof};
      wr_ptr_d = !wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = !rd_ptr_q;
    end
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q].data;
  assign head_sol  = mem_q[rd_ptr_q].sol;
  assign head_eof  = mem_q[rd_ptr_q].eof;
  assign count     = count_q;

endmodule

// File: rtl/translate_gather_reader.sv
// Raster-scans the output frame, gathers translated source pixels.
// TRANSLATE_WRAP_EN: wrap out-of-bounds sources instead of FILL.
module translate_gather_reader
  import translate_pkg::*;
#(
  parameter int          ROWS        = 512,
  parameter int          COLS        = 512,
  parameter int          TRANSLATE_X = -50,
  parameter int          TRANSLATE_Y = 40,
  parameter logic [7:0]  FILL        = 8'd0,
  localparam int         AW          = $clog2(ROWS * COLS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_rd_addr,
  input  logic [7:0]    mem_rd_data,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic [7:0]    pix_data,
  output logic          pix_sol,
  output logic          pix_eof
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  state_t        state_q, state_d;
  logic [RW-1:0] i_q, i_d;
  logic [CW-1:0] j_q, j_d;
  logic          cap_q, cap_d;
  logic          cap_fill_q, cap_fill_d;
  logic          cap_sol_q, cap_sol_d;
  logic          cap_eof_q, cap_eof_d;

  int            src_i, src_j;
  logic          in_b, last, issue, pop, credit;
  logic [1:0]    fifo_cnt;
  logic [7:0]    head_data;
  logic          head_sol, head_eof;
  pixel_t        cap_data;

  always_comb begin
    src_i = int'(i_q) - TRANSLATE_Y;
    src_j = int'(j_q) - TRANSLATE_X;
`ifdef TRANSLATE_WRAP_EN
    if (src_i < 0) src_i = src_i + ROWS;
    else if (src_i >= ROWS) src_i = src_i - ROWS;
    if (src_j < 0) src_j = src_j + COLS;
    else if (src_j >= COLS) src_j = src_j - COLS;
    in_b = 1'b1;
`else
    in_b = (src_i >= 0) && (src_i < ROWS) &&
           (src_j >= 0) && (src_j < COLS);
`endif
    last = (i_q == RW'(ROWS - 1)) && (j_q == CW'(COLS - 1));
    pop  = pix_valid && pix_ready;
    // Occupancy after this edge plus the new issue must fit the FIFO
    credit = (int'(fifo_cnt) + int'(cap_q) - int'(pop)) < FIFO_DEPTH;
    issue  = (state_q == RUN) && credit;
    mem_rd_en   = issue && in_b;
    mem_rd_addr = mem_rd_en ? AW'(src_i * COLS + src_j) : '0;
  end

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    cap_d      = issue;
    cap_fill_d = !in_b;
    cap_sol_d  = (j_q == '0);
    cap_eof_d  = last;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          i_d     = '0;
          j_d     = '0;
        end
      end
      RUN: begin
        if (issue) begin
          if (j_q == CW'(COLS - 1)) begin
            j_d = '0;
            i_d = i_q + 1'b1;
          end else begin
            j_d = j_q + 1'b1;
          end
          if (last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!cap_q && (int'(fifo_cnt) - int'(pop) == 0)) begin
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      i_q        <= '0;
      j_q        <= '0;
      cap_q      <= 1'b0;
      cap_fill_q <= 1'b0;
      cap_sol_q  <= 1'b0;
      cap_eof_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      cap_q      <= cap_d;
      cap_fill_q <= cap_fill_d;
      cap_sol_q  <= cap_sol_d;
      cap_eof_q  <= cap_eof_d;
    end
  end

  assign cap_data = cap_fill_q ? FILL : mem_rd_data;

  translate_pix_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cap_q),
    .push_data (cap_data),
    .push_sol  (cap_sol_q),
    .push_eof  (cap_eof_q),
    .pop       (pop),
    .head_data (head_data),
    .head_sol  (head_sol),
    .head_eof  (head_eof),
    .count     (fifo_cnt)
  );

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign pix_valid = (fifo_cnt != 2'd0);
  assign pix_data  = pix_valid ? head_data : 8'd0;
  assign pix_sol   = pix_valid && head_sol;
  assign pix_eof   = pix_valid && head_eof;

endmodule

// File: tb/tb_translate_gather_reader.sv
// Scoreboard bench: 8x8 frames, shifted and identity instances.
module tb_translate_gather_reader;

  localparam int N  = 8;
  localparam int TX = -2;
  localparam int TY = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       pix_ready = 1'b1;
  logic       busy, done, mem_rd_en;
  logic [5:0] mem_rd_addr;
  logic [7:0] mem_rd_data = 8'h00;
  logic       pix_valid, pix_sol, pix_eof;
  logic [7:0] pix_data;

  logic       start2 = 1'b0;
  logic       ready2 = 1'b1;
  logic       busy2, done2, en2;
  logic [5:0] addr2;
  logic [7:0] rdata2 = 8'h00;
  logic       valid2, sol2, eof2;
  logic [7:0] data2;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int reads = 0;
  int reads2 = 0;
  bit rand_mode = 1'b0;
  bit sb_on = 1'b0;

  logic [9:0] q1[$];
  logic [9:0] q2[$];
  logic [9:0] got, expv, held;
  logic [9:0] got2;
  bit   stalled = 1'b0;
  int   nhs = 0, ndone = 0, first_cyc = 0, last_cyc = 0, eof_cyc = 0;
  int   ndone2 = 0, first2 = 0, last2 = 0;

  always #5 clk = ~clk;

  translate_gather_reader #(
    .ROWS(N), .COLS(N), .TRANSLATE_X(TX), .TRANSLATE_Y(TY), .FILL(8'd0)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_data(pix_data), .pix_sol(pix_sol),
    .pix_eof(pix_eof)
  );

  translate_gather_reader #(
    .ROWS(N), .COLS(N), .TRANSLATE_X(0), .TRANSLATE_Y(0), .FILL(8'd0)
  ) dut_id (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
    .mem_rd_en(en2), .mem_rd_addr(addr2), .mem_rd_data(rdata2),
    .pix_valid(valid2), .pix_ready(ready2), .pix_data(data2),
    .pix_sol(sol2), .pix_eof(eof2)
  );

  // Frame memory holds src(r,c) = 8r+c, i.e. the address itself
  always @(posedge clk) begin
    cyc <= cyc + 1;
    mem_rd_data <= mem_rd_en ? {2'b00, mem_rd_addr} : 8'hEE;
    rdata2 <= en2 ? {2'b00, addr2} : 8'hEE;
    if (mem_rd_en) reads <= reads + 1;
    if (en2) reads2 <= reads2 + 1;
  end

  function automatic void check(string nm, int act, int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, req);
  endfunction

  function automatic bit src_ok(int i, int j, int tx, int ty);
`ifdef TRANSLATE_WRAP_EN
    return 1'b1;
`else
    return (i - ty >= 0) && (i - ty < N) && (j - tx >= 0) && (j - tx < N);
`endif
  endfunction

  function automatic logic [9:0] ref_pix(int i, int j, int tx, int ty);
    int si, sj;
    logic [7:0] d;
    si = i - ty;
    sj = j - tx;
`ifdef TRANSLATE_WRAP_EN
    si = ((si % N) + N) % N;
    sj = ((sj % N) + N) % N;
`endif
    if (si >= 0 && si < N && sj >= 0 && sj < N) d = 8'(N * si + sj);
    else d = 8'h00;
    return {(i == N - 1) && (j == N - 1), j == 0, d};
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      pix_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!sb_on) begin
      stalled = 1'b0;
    end else begin
      if (stalled)
        check("hold", int'({pix_valid, pix_eof, pix_sol, pix_data}),
              int'({1'b1, held}));
      stalled = 1'b0;
      got = {pix_eof, pix_sol, pix_data};
      if (pix_valid && !pix_ready) begin
        stalled = 1'b1;
        held = got;
      end else if (pix_valid) begin
        if (q1.size() == 0) begin
          check("extra_pix", int'(got), -1);
        end else begin
          if (q1.size() == N * N) first_cyc = cyc;
          expv = q1.pop_front();
          check($sformatf("pix%0d", N * N - 1 - q1.size()),
                int'(got), int'(expv));
        end
        if (pix_eof) eof_cyc = cyc;
        last_cyc = cyc;
        nhs++;
      end
    end
    if (done) begin
      ndone++;
      if (sb_on) check("done_timing", cyc, eof_cyc + 1);
    end
  end

  always @(negedge clk) begin
    if (valid2) begin
      got2 = {eof2, sol2, data2};
      if (q2.size() == 0) begin
        check("extra_pix_id", int'(got2), -1);
      end else begin
        if (q2.size() == N * N) first2 = cyc;
        check("id_pix", int'(got2), int'(q2.pop_front()));
      end
      last2 = cyc;
    end
    if (done2) ndone2++;
  end

  task automatic pulse_start();
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic queue_frame(output int exp_reads);
    exp_reads = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        q1.push_back(ref_pix(i, j, TX, TY));
        if (src_ok(i, j, TX, TY)) exp_reads++;
      end
  endtask

  task automatic wait_hs(input int target);
    int t = 0;
    while (nhs < target && t < 1000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 1000) check("wait_pixel_timeout", nhs, target);
  endtask

  task automatic run_frame(input bit rnd, input bit chk_lat);
    int base_r, base_d, st, t, exp_reads;
    rand_mode = rnd;
    base_r = reads;
    base_d = ndone;
    queue_frame(exp_reads);
    sb_on = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b1;
    st = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    t = 0;
    while (ndone == base_d && t < 3000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 3000) check("frame_timeout", ndone - base_d, 1);
    repeat (4) @(posedge clk);
    #1;
    check("reads", reads - base_r, exp_reads);
    check("queue_empty", q1.size(), 0);
    check("done_count", ndone - base_d, 1);
    check("busy_after", int'(busy), 0);
    if (chk_lat) begin
      check("latency", first_cyc - st, 3);
      check("throughput", last_cyc - first_cyc, N * N - 1);
    end
    rand_mode = 1'b0;
  endtask

  initial begin
    int base_d, base_h, base_r, st, t, er;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_rd_en", int'(mem_rd_en), 0);
    check("rst_addr", int'(mem_rd_addr), 0);
    check("rst_outs", int'({pix_valid, pix_sol, pix_eof, pix_data}), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_frame(1'b0, 1'b1);
    run_frame(1'b1, 1'b0);
    run_frame(1'b1, 1'b0);

    // Start while busy is ignored, then reset aborts mid-frame
    queue_frame(er);
    sb_on = 1'b1;
    base_h = nhs;
    pulse_start();
    wait_hs(base_h + 20);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_hs(base_h + 30);
    sb_on = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("abort_busy", int'(busy), 0);
    check("abort_rd_en", int'(mem_rd_en), 0);
    check("abort_outs", int'({pix_valid, pix_sol, pix_eof, pix_data}), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q1.delete();
    base_d = ndone;
    repeat (12) @(posedge clk);
    #1;
    check("no_done_after_rst", ndone - base_d, 0);
    check("idle_after_rst", int'({busy, pix_valid}), 0);

    run_frame(1'b0, 1'b1);

    // Identity instance
    check("id_idle", int'(busy2), 0);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) q2.push_back(ref_pix(i, j, 0, 0));
    base_r = reads2;
    base_d = ndone2;
    @(posedge clk);
    #1;
    start2 = 1'b1;
    st = cyc;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    t = 0;
    while (ndone2 == base_d && t < 3000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 3000) check("id_timeout", ndone2 - base_d, 1);
    repeat (4) @(posedge clk);
    #1;
    check("id_reads", reads2 - base_r, N * N);
    check("id_queue_empty", q2.size(), 0);
    check("id_done_count", ndone2 - base_d, 1);
    check("id_latency", first2 - st, 3);
    check("id_throughput", last2 - first2, N * N - 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
